// File: rtl/counter_mod.sv
// counter_mod -- parametrised modulo up/down counter with an enable prescaler.
//
// Counts 0..MODULO-1 in either direction. Each count step is taken once per
// PRESC enabled cycles. The counter can free-run (wrapping, with a one-cycle
// terminal-count pulse) or run one-shot (stop at the terminal value and set
// a sticky done flag). Synchronous clear and parallel load restart it.
//
// Parameters:
//   BW      counter width in bits (>= 1)
//   MODULO  count range, 2 <= MODULO <= 2**BW
//   PRESC   enabled cycles per count step (>= 1)
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset, overrides everything
//   en_i        count enable, gates the prescaler
//   up_i        direction, 1 = up, 0 = down (sampled at each step)
//   oneshot_i   1 = one-shot, 0 = free-running (sampled at each step)
//   clr_i       synchronous clear to the start value of the current direction
//   load_i      synchronous parallel load of loadVal_i (clamped to MODULO-1)
//   loadVal_i   load value
//   cmpVal_i    compare value
//   count_o     registered count
//   tc_o        registered terminal-count pulse, one cycle wide
//   done_o      registered sticky one-shot finished flag
//   cmpMatch_o  combinational, high while count_o == cmpVal_i

module counter_mod #(
  parameter int BW     = 4,
  parameter int MODULO = 2**BW,
  parameter int PRESC  = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          up_i,
  input  logic          oneshot_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [BW-1:0] loadVal_i,
  input  logic [BW-1:0] cmpVal_i,
  output logic [BW-1:0] count_o,
  output logic          tc_o,
  output logic          done_o,
  output logic          cmpMatch_o
);

  // Reject illegal parameterisations at elaboration time.
  if (BW < 1 || MODULO < 2 || MODULO > 2**BW || PRESC < 1) begin : g_bad_param
    $fatal(1, "counter_mod: illegal parameters BW=%0d MODULO=%0d PRESC=%0d",
           BW, MODULO, PRESC);
  end

  localparam int              PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [BW-1:0]   MAX_VAL    = BW'(MODULO - 1);
  localparam logic [BW:0]     MOD_EXT    = (BW+1)'(MODULO);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);

  logic [BW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tc_q, tc_d;
  logic          done_q, done_d;

  // Candidate step results. The up increment is one bit wider than the
  // counter so that MODULO = 2**BW still detects the wrap point.
  logic [BW:0]   inc_ext;
  logic [BW-1:0] up_next, dn_next, step_next, term_val, load_clamped;
  logic          up_wrap, dn_wrap, step_wrap;

  always_comb begin
    inc_ext      = {1'b0, count_q} + (BW+1)'(1);
    up_wrap      = (inc_ext == MOD_EXT);
    up_next      = up_wrap ? '0 : inc_ext[BW-1:0];
    dn_wrap      = (count_q == '0);
    dn_next      = dn_wrap ? MAX_VAL : count_q - BW'(1);
    step_next    = up_i ? up_next : dn_next;
    step_wrap    = up_i ? up_wrap : dn_wrap;
    term_val     = up_i ? MAX_VAL : '0;
    load_clamped = ({1'b0, loadVal_i} >= MOD_EXT) ? MAX_VAL : loadVal_i;
  end

  // Next-state logic. Priority: clear, load, then prescaled step. Once a
  // one-shot run is done, enable is ignored entirely so the prescaler also
  // freezes until a clear, load or reset.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    done_d  = done_q;
    tc_d    = 1'b0;

    if (clr_i) begin
      count_d = up_i ? '0 : MAX_VAL;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (load_i) begin
      count_d = load_clamped;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (en_i && !done_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (oneshot_i) begin
          // Already sitting on the terminal value: finish without moving.
          if (count_q == term_val) begin
            done_d = 1'b1;
            tc_d   = 1'b1;
          end else begin
            count_d = step_next;
            if (step_next == term_val) begin
              done_d = 1'b1;
              tc_d   = 1'b1;
            end
          end
        end else begin
          count_d = step_next;
          tc_d    = step_wrap;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count_o    = count_q;
  assign tc_o       = tc_q;
  assign done_o     = done_q;
  assign cmpMatch_o = (count_q == cmpVal_i);

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo up/down counter. Successor to the basic `counter` block, adding:
- configurable modulus and enable prescaler;
- direction control, parallel load and synchronous clear;
- one-shot mode, terminal-count pulse and a compare output.

It serves as the general timing/event counter for timers, PWM and sequencing logic in the design.

## Interface
Parameters:
- `BW`, 4: counter width in bits. Must be at least 1.
- `MODULO`, 2**BW: count range; counts 0..MODULO-1. Legal range 2 ≤ MODULO ≤ 2**BW; an illegal value is a fatal elaboration error.
- `PRESC`, 1: number of enabled cycles per count step. Must be at least 1; 1 means a step on every enabled cycle.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: count enable; gates the prescaler.
- `up_i` in 1: direction; 1 = up, 0 = down. Sampled at each step.
- `oneshot_i` in 1: 1 = one-shot mode, 0 = free-running. Sampled at each step.
- `clr_i` in 1: synchronous clear to the start value.
- `load_i` in 1: synchronous parallel load.
- `loadVal_i` in BW: load value. Values ≥ MODULO are clamped to MODULO-1.
- `cmpVal_i` in BW: compare value.
- `count_o` out BW: registered count.
- `tc_o` out 1: registered terminal-count pulse, one cycle wide.
- `done_o` out 1: registered; one-shot finished, sticky.
- `cmpMatch_o` out 1: combinational; `count_o == cmpVal_i`.

## Operation
- **Reset** (`rst_i`=1):
  - count_o=0, tc_o=0, done_o=0, prescaler=0.
  - Overrides all other inputs.
- **Priority per cycle:** rst_i > clr_i > load_i > step > hold.
- **Clear:**
  - Up (`up_i`=1): count_o ← 0.
  - Down (`up_i`=0): count_o ← MODULO-1.
  - Also: prescaler ← 0, done_o ← 0, tc_o ← 0.
- **Load:** count_o ← min(loadVal_i, MODULO-1); prescaler ← 0, done_o ← 0, tc_o ← 0.
- **Prescaler:**
  - Counts enabled cycles 0..PRESC-1 and holds while en_i=0.
  - A step occurs on a cycle where en_i=1 and prescaler=PRESC-1; the prescaler returns to 0 on that cycle.
- **Step, free-running** (done_o=0, oneshot_i=0):
  - Up: count+1. MODULO-1 wraps to 0.
  - Down: count-1. 0 wraps to MODULO-1.
  - tc_o=1 on the cycle after a wrap step, coincident with the wrapped count_o.
- **Step, one-shot** (oneshot_i=1):
  - Counts as above, but a step whose result equals the terminal value sets done_o=1 and tc_o=1 together with that count.
  - Terminal value is MODULO-1 when up, 0 when down.
  - If the count already equals the terminal value when a step is taken: done_o ← 1, tc_o pulses, count holds.
  - While done_o=1:
    - steps are suppressed (count, tc_o and the prescaler hold);
    - en_i has no effect;
    - only clr_i, load_i or rst_i restart the counter.
- **Mode or direction change mid-count:** no state reset; takes effect at the next step. Terminal and wrap values follow the `up_i` value at that step.
- **tc_o** is 0 in every cycle not explicitly described above.
- **Arithmetic:** internal next-count is BW+1 bits wide so MODULO=2**BW wraps correctly. No value ≥ MODULO is ever stored.

## Timing
- count_o, tc_o and done_o change only on the rising clk_i edge; cmpMatch_o follows count_o within the same cycle.
- Latency:
  - Clear, load and reset are visible on count_o one cycle after being sampled.
  - A step is visible on count_o one cycle after the enabling edge.
- Step rate: once per PRESC cycles with en_i held high. With PRESC=1, one step per cycle.
- Simultaneous clr_i and load_i: clear wins. load_i and a step: load wins, no step.
- Reset mid-count or mid-prescale: all state returns to reset values on the next edge; no partial step.

## Test plan
- **Reset / free-running up** (BW=4, MODULO=10, PRESC=1): apply reset, then en_i=1, up_i=1 for 12 cycles.
  - count_o goes 0..9,0,1,2.
  - tc_o is high only in the cycle count_o=0 after 9.
- **Down counting and clear:** clr_i with up_i=0 gives count_o=9. Then 10 enabled steps.
  - count_o goes 9..0,9.
  - tc_o is high with the second 9.
- **Prescaler** (PRESC=3): en_i=1 for 9 cycles, then en_i=0 for 2 cycles.
  - count_o goes 0→3, changing every 3rd cycle.
  - count_o holds while en_i=0, and the prescaler phase is preserved.
- **One-shot up** (MODULO=10): load 7, oneshot_i=1, en_i=1.
  - count_o goes 8, 9; done_o=1 and tc_o=1 with 9.
  - count_o stays 9 for 5+ further cycles and tc_o stays 0.
  - load 2 clears done_o.
- **Load clamp and priority:**
  - loadVal_i=15 with MODULO=10 gives count_o=9.
  - clr_i with load_i together gives the clear value.
  - load_i during an enabled step loads, with no step.
- **Compare and reset mid-operation:** cmpVal_i=5.
  - cmpMatch_o is high exactly while count_o=5.
  - rst_i asserted at count 6, prescaler mid-phase: next cycle count_o=0, done_o=0, tc_o=0, and the first step occurs PRESC cycles later.
